// File: rtl/cdiv_pkg.sv
// Shared types and width helpers for the sequential complex divider.
package cdiv_pkg;

    localparam int CDIV_W = 8;

    // Numerator needs 3W+1 signed bits, denominator 2W+1 unsigned bits.
    function automatic int num_width(input int w);
        return 3 * w + 1;
    endfunction

    function automatic int den_width(input int w);
        return 2 * w + 1;
    endfunction

    // Iteration counter must hold 3W (loaded value) and fit 3W+2 codes.
    function automatic int cnt_width(input int w);
        return $clog2(3 * w + 2);
    endfunction

    localparam int CDIV_NW = num_width(CDIV_W);
    localparam int CDIV_DW = den_width(CDIV_W);
    localparam int CDIV_CW = cnt_width(CDIV_W);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/cdiv_udiv_step.sv
// One restoring-division iteration. quo holds the not-yet-consumed
// dividend bits in its upper part and the quotient bits built so far in
// its lower part; each step consumes the MSB and appends one quotient bit.
module cdiv_udiv_step #(
    parameter int NW = 25,
    parameter int DW = 17
) (
    input  logic [DW-1:0] rem,
    input  logic [NW-1:0] quo,
    input  logic [DW-1:0] den,
    output logic [DW-1:0] rem_next,
    output logic [NW-1:0] quo_next
);

    logic [DW:0] trial;
    logic        fits;

    // Shift in the next dividend bit, subtract when the trial remainder covers den.
    always_comb begin
        trial    = {rem, quo[NW-1]};
        fits     = (trial >= {1'b0, den});
        rem_next = fits ? DW'(trial - {1'b0, den}) : trial[DW-1:0];
        quo_next = {quo[NW-2:0], fits};
    end

endmodule

// File: rtl/complex_divider.sv
// Sequential complex divider: quotient = dividend / divisor, truncated
// toward zero and saturated to W-bit parts. Fixed latency of 3W+3 cycles
// from the accept edge to out_valid.
//
//  state | meaning
//  IDLE  | ready for operands
//  MUL   | form numerators, denominator and numerator signs
//  DIV   | 3W+1 restoring iterations on both magnitudes
//  FIX   | reapply signs, saturate, register result and flags
//  DONE  | result valid, waiting for out_ready
module complex_divider
    import cdiv_pkg::*;
#(
    parameter int W = CDIV_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4*W-1:0] dividend,
    input  logic [2*W-1:0] divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] quotient,
    output logic           div_by_zero,
    output logic           saturated
);

    localparam int NW = num_width(W);
    localparam int DW = den_width(W);
    localparam int CW = cnt_width(W);

    localparam logic signed [NW:0] Q_MAX = (NW+1)'((1 << (W-1)) - 1);
    localparam logic signed [NW:0] Q_MIN = -Q_MAX - 1;

    state_t state, state_next;

    logic signed [2*W-1:0] p_re, p_im;
    logic signed [W-1:0]   d_re, d_im;

    logic signed [NW-1:0]  n_re_c, n_im_c;
    logic [DW-1:0]         den_c;

    logic [NW-1:0]         quo_re, quo_im, quo_re_next, quo_im_next;
    logic [DW-1:0]         rem_re, rem_im, rem_re_next, rem_im_next;
    logic [DW-1:0]         den;
    logic                  neg_re, neg_im;
    logic [CW-1:0]         cnt;

    logic signed [NW:0]    q_re_s, q_im_s;
    logic [W-1:0]          q_re_sat, q_im_sat;
    logic                  clip_re, clip_im;

    // Clip a signed quotient part into the W-bit two's-complement range.
    function automatic logic [W:0] sat_part(input logic signed [NW:0] v);
        if (v > Q_MAX)
            return {1'b1, Q_MAX[W-1:0]};
        else if (v < Q_MIN)
            return {1'b1, Q_MIN[W-1:0]};
        else
            return {1'b0, v[W-1:0]};
    endfunction

    cdiv_udiv_step #(.NW(NW), .DW(DW)) u_step_re (
        .rem      (rem_re),
        .quo      (quo_re),
        .den      (den),
        .rem_next (rem_re_next),
        .quo_next (quo_re_next)
    );

    cdiv_udiv_step #(.NW(NW), .DW(DW)) u_step_im (
        .rem      (rem_im),
        .quo      (quo_im),
        .den      (den),
        .rem_next (rem_im_next),
        .quo_next (quo_im_next)
    );

    // Complex numerator (dividend times conjugate divisor) and squared magnitude.
    always_comb begin
        n_re_c = NW'(p_re) * NW'(d_re) + NW'(p_im) * NW'(d_im);
        n_im_c = NW'(p_im) * NW'(d_re) - NW'(p_re) * NW'(d_im);
        den_c  = DW'(d_re) * DW'(d_re) + DW'(d_im) * DW'(d_im);
    end

    // Sign restoration and saturation of the unsigned quotients.
    always_comb begin
        q_re_s = neg_re ? -$signed({1'b0, quo_re}) : $signed({1'b0, quo_re});
        q_im_s = neg_im ? -$signed({1'b0, quo_im}) : $signed({1'b0, quo_im});
        {clip_re, q_re_sat} = sat_part(q_re_s);
        {clip_im, q_im_sat} = sat_part(q_im_s);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = MUL;
            end
            MUL:  state_next = DIV;
            DIV: begin
                if (cnt == '0)
                    state_next = FIX;
            end
            FIX:  state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, setup, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_re        <= '0;
            p_im        <= '0;
            d_re        <= '0;
            d_im        <= '0;
            quo_re      <= '0;
            quo_im      <= '0;
            rem_re      <= '0;
            rem_im      <= '0;
            den         <= '0;
            neg_re      <= 1'b0;
            neg_im      <= 1'b0;
            cnt         <= '0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
            saturated   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        p_re <= dividend[4*W-1:2*W];
                        p_im <= dividend[2*W-1:0];
                        d_re <= divisor[2*W-1:W];
                        d_im <= divisor[W-1:0];
                    end
                end
                MUL: begin
                    neg_re <= n_re_c[NW-1];
                    neg_im <= n_im_c[NW-1];
                    quo_re <= n_re_c[NW-1] ? $unsigned(-n_re_c) : $unsigned(n_re_c);
                    quo_im <= n_im_c[NW-1] ? $unsigned(-n_im_c) : $unsigned(n_im_c);
                    den    <= den_c;
                    rem_re <= '0;
                    rem_im <= '0;
                    cnt    <= CW'(NW - 1);
                end
                DIV: begin
                    quo_re <= quo_re_next;
                    quo_im <= quo_im_next;
                    rem_re <= rem_re_next;
                    rem_im <= rem_im_next;
                    cnt    <= cnt - 1'b1;
                end
                FIX: begin
                    // A zero denominator leaves garbage in quo; report zero instead.
                    if (den == '0) begin
                        quotient    <= '0;
                        div_by_zero <= 1'b1;
                        saturated   <= 1'b0;
                    end else begin
                        quotient    <= {q_re_sat, q_im_sat};
                        div_by_zero <= 1'b0;
                        saturated   <= clip_re | clip_im;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_complex_divider.sv
// Bench for complex_divider: directed cases plus random operands against
// an arithmetic model of complex division.
module tb_complex_divider;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [4*W-1:0] dividend = '0;
    logic [2*W-1:0] divisor = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] quotient;
    logic           div_by_zero;
    logic           saturated;

    int checks = 0;
    int errors = 0;

    complex_divider #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .div_by_zero (div_by_zero),
        .saturated   (saturated)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint clip(input longint v, output bit c);
        c = 1'b0;
        if (v > 127) begin
            c = 1'b1;
            return 127;
        end
        if (v < -128) begin
            c = 1'b1;
            return -128;
        end
        return v;
    endfunction

    // Complex division with integer truncation toward zero.
    task automatic model(input longint pr, pi, dr, di,
                         output longint qr, qi, output bit sat, output bit dbz);
        longint nr, ni, den;
        bit cr, ci;
        den = dr * dr + di * di;
        if (den == 0) begin
            qr = 0; qi = 0; sat = 0; dbz = 1;
        end else begin
            nr  = pr * dr + pi * di;
            ni  = pi * dr - pr * di;
            qr  = clip(nr / den, cr);
            qi  = clip(ni / den, ci);
            sat = cr | ci;
            dbz = 0;
        end
    endtask

    task automatic do_op(input string tag, input longint pr, pi, dr, di,
                         input longint er, ei, input bit es, ed,
                         input int hold, input bit poke);
        int lat;
        logic [2*W-1:0] q_seen;
        @(negedge clk);
        check({tag, "_ready"}, in_ready, 1);
        dividend  = {16'(pr), 16'(pi)};
        divisor   = {8'(dr), 8'(di)};
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 60) begin
            if (poke && lat == 10) begin
                in_valid = 1'b1;
                check({tag, "_busy"}, in_ready, 0);
            end
            if (poke && lat == 15)
                in_valid = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_lat"}, lat, 27);
        check({tag, "_qre"}, $signed(quotient[15:8]), 32'(er));
        check({tag, "_qim"}, $signed(quotient[7:0]), 32'(ei));
        check({tag, "_sat"}, saturated, es);
        check({tag, "_dbz"}, div_by_zero, ed);
        q_seen = quotient;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_v"}, out_valid, 1);
            check({tag, "_hold_q"}, quotient, q_seen);
            check({tag, "_hold_rdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_rel_v"}, out_valid, 0);
        check({tag, "_rel_rdy"}, in_ready, 1);
    endtask

    longint pr, pi, dr, di, qr, qi;
    bit sat, dbz;
    logic signed [15:0] r16a, r16b;
    logic signed [7:0]  r8a, r8b;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_q", quotient, 0);
        check("rst_flags", {div_by_zero, saturated}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("rt",    8, 16, 6, 2,  2, 2, 0, 0, 0, 0);
        do_op("sgn1", -8, 6, 0, 2,   3, 4, 0, 0, 0, 0);
        do_op("sgn2", -7, 0, 2, 0,  -3, 0, 0, 0, 0, 0);
        do_op("satp", 32767, 0, 1, 0,  127, 0, 1, 0, 0, 0);
        do_op("satn", -32768, 0, 1, 0, -128, 0, 1, 0, 0, 0);
        do_op("dbz",  1234, -55, 0, 0,  0, 0, 0, 1, 0, 0);
        do_op("bp",   8, 16, 6, 2,  2, 2, 0, 0, 10, 0);
        do_op("poke", -7, 0, 2, 0, -3, 0, 0, 0, 1, 1);
        do_op("b2b",  -8, 6, 0, 2,  3, 4, 0, 0, 0, 0);

        // Reset in the middle of DIV.
        @(negedge clk);
        dividend = {16'sd8, 16'sd16};
        divisor  = {8'sd6, 8'sd2};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("post_rst_valid", out_valid, 0);
        do_op("after_rst", 8, 16, 6, 2, 2, 2, 0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            r16a = 16'($urandom);
            r16b = 16'($urandom);
            if (n % 4 == 0) begin
                r8a = 8'($signed($urandom_range(0, 6)) - 3);
                r8b = 8'($signed($urandom_range(0, 6)) - 3);
            end else begin
                r8a = 8'($urandom);
                r8b = 8'($urandom);
            end
            pr = r16a; pi = r16b; dr = r8a; di = r8b;
            model(pr, pi, dr, di, qr, qi, sat, dbz);
            do_op($sformatf("rnd%0d", n), pr, pi, dr, di, qr, qi, sat, dbz,
                  int'($urandom_range(0, 3)), bit'(n % 5 == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
